// File: rtl/sram_exp_pipe_pkg.sv
// Shared BF16 field constants, special encodings and the operand class enum
// used by the table-driven exp(x) pipeline.
package sram_exp_pipe_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 7;
    localparam int BIAS  = 127;

    localparam logic [EXP_W-1:0] EXP_ALL_ONES = 8'hFF;

    localparam logic [15:0] QNAN = 16'h7FC0;
    localparam logic [15:0] ONE  = 16'h3F80;

    typedef enum logic [1:0] {
        NORM  = 2'd0,
        SMALL = 2'd1,
        BIG   = 2'd2,
        NAN   = 2'd3
    } exp_class_e;

endpackage

// File: rtl/sram_exp_pipe_bf16_mul.sv
// Combinational BF16 multiply: round-to-nearest-even, subnormals flushed to
// signed zero on input and output, overflow saturates to signed infinity.
module bf16_mul
    import sram_exp_pipe_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p
);

    logic               sign;
    logic [EXP_W-1:0]   ea;
    logic [EXP_W-1:0]   eb;
    logic [15:0]        prod;
    logic [MAN_W-1:0]   mant;
    logic               rnd;
    logic               sticky;
    logic [MAN_W:0]     mant_r;
    logic signed [10:0] exp_v;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    always_comb begin
        sign   = a[15] ^ b[15];
        ea     = a[14:7];
        eb     = b[14:7];
        a_nan  = (ea == EXP_ALL_ONES) && (a[6:0] != '0);
        b_nan  = (eb == EXP_ALL_ONES) && (b[6:0] != '0);
        a_inf  = (ea == EXP_ALL_ONES) && (a[6:0] == '0);
        b_inf  = (eb == EXP_ALL_ONES) && (b[6:0] == '0);
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        prod   = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});

        // Product of two 1.x significands lies in [1,4): pick the normalising shift.
        if (prod[15]) begin
            mant   = prod[14:8];
            rnd    = prod[7];
            sticky = |prod[6:0];
        end else begin
            mant   = prod[13:7];
            rnd    = prod[6];
            sticky = |prod[5:0];
        end
        mant_r = {1'b0, mant} + {7'b0, (rnd && (sticky || mant[0]))};
        exp_v  = 11'(ea) + 11'(eb) - 11'sd127 + 11'(prod[15]) + 11'(mant_r[MAN_W]);

        p = {sign, 15'h0};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            p = QNAN;
        end else if (a_inf || b_inf) begin
            p = {sign, EXP_ALL_ONES, 7'h0};
        end else if (a_zero || b_zero) begin
            p = {sign, 15'h0};
        end else if (exp_v >= 11'sd255) begin
            p = {sign, EXP_ALL_ONES, 7'h0};
        end else if (exp_v <= 11'sd0) begin
            p = {sign, 15'h0};
        end else begin
            p = {sign, exp_v[7:0], mant_r[MAN_W-1:0]};
        end
    end

endmodule

// File: rtl/sram_exp_pipe.sv
// Two-stage BF16 exp(x): a split hi/lo table lookup whose entries are
// multiplied together, with special classes (NaN, overflow, tiny) bypassed.
module sram_exp_pipe
    import sram_exp_pipe_pkg::*;
#(
    parameter  int EMIN = -7,
    parameter  int EMAX = 6,
    parameter  int MHI  = 4,
    localparam int EW   = $clog2(EMAX - EMIN),
    localparam int AW   = EW + MHI + 1,
    localparam int LW   = EW + 8 - MHI
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_data,
    input  logic          tbl_we,
    input  logic          tbl_sel,
    input  logic [AW-1:0] tbl_addr,
    input  logic [15:0]   tbl_wdata
);

    localparam logic [EXP_W-1:0] E_LO = 8'(BIAS + EMIN);
    localparam logic [EXP_W-1:0] E_HI = 8'(BIAS + EMAX);

    logic             adv;
    logic             x_sign;
    logic [EXP_W-1:0] x_exp;
    logic [MAN_W-1:0] x_man;
    logic [EW-1:0]    e_adj;
    logic [AW-1:0]    hi_idx;
    logic [LW-1:0]    lo_idx;
    exp_class_e       x_class;

    logic [15:0]      hi_mem [2**AW];
    logic [15:0]      lo_mem [2**LW];
    logic [15:0]      hi_rd_reg;
    logic [15:0]      lo_rd_reg;

    logic             s1_valid_reg;
    logic             s1_sign_reg;
    exp_class_e       s1_class_reg;
    logic             s2_valid_reg;
    logic [15:0]      out_data_reg;
    logic [15:0]      prod;
    logic [15:0]      result;

    assign adv       = !s2_valid_reg || out_ready;
    assign in_ready  = adv;
    assign out_valid = s2_valid_reg;
    assign out_data  = out_data_reg;

    assign x_sign = in_data[15];
    assign x_exp  = in_data[14:7];
    assign x_man  = in_data[6:0];
    assign e_adj  = EW'(x_exp - E_LO);
    assign hi_idx = {e_adj, x_man[MAN_W-1 -: MHI], x_sign};
    assign lo_idx = {e_adj, x_man[MAN_W-1-MHI:0], x_sign};

    always_comb begin
        x_class = NORM;
        if ((x_exp == EXP_ALL_ONES) && (x_man != '0)) begin
            x_class = NAN;
        end else if (x_exp >= E_HI) begin
            x_class = BIG;
        end else if (x_exp < E_LO) begin
            x_class = SMALL;
        end
    end

    // Tables have no reset; the read port only moves on an advance so a stall
    // freezes the looked-up operands together with the rest of S1.
    always_ff @(posedge clk) begin
        if (tbl_we && !tbl_sel) begin
            hi_mem[tbl_addr] <= tbl_wdata;
        end
        if (adv) begin
            hi_rd_reg <= hi_mem[hi_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we && tbl_sel) begin
            lo_mem[tbl_addr[LW-1:0]] <= tbl_wdata;
        end
        if (adv) begin
            lo_rd_reg <= lo_mem[lo_idx];
        end
    end

    bf16_mul u_mul (
        .a (hi_rd_reg),
        .b (lo_rd_reg),
        .p (prod)
    );

    always_comb begin
        result = prod;
        case (s1_class_reg)
            NAN:     result = QNAN;
            BIG:     result = {1'b0, {8{!s1_sign_reg}}, 7'b0};
            SMALL:   result = ONE;
            default: result = prod;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            out_data_reg <= 16'h0000;
        end else if (adv) begin
            s1_valid_reg <= in_valid;
            s1_class_reg <= x_class;
            s1_sign_reg  <= x_sign;
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_data_reg <= result;
            end
        end
    end

endmodule

// File: doc/sram_exp_pipe.md
SRAM_EXP_PIPE -- requirements
Module: sram_exp_pipe

Interface
REQ-001 SHALL have parameter EMIN, default -7, the smallest unbiased exponent served by the tables.
REQ-002 SHALL have parameter EMAX, default 6; inputs with unbiased exponent >= EMAX saturate.
REQ-003 SHALL have parameter MHI, default 4, the mantissa bits indexing the hi table; the lo table uses the remaining 7-MHI bits.
REQ-004 SHALL have port clk, input, 1, the single clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, BF16 operand present.
REQ-007 SHALL have port in_ready, output, 1, operand accepted on this edge if in_valid is high.
REQ-008 SHALL have port in_data, input, 16, BF16 x.
REQ-009 SHALL have port out_valid, output, 1, result present.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the result on this edge.
REQ-011 SHALL have port out_data, output, 16, BF16 exp(x) approximation.
REQ-012 SHALL have port tbl_we, input, 1, table write strobe.
REQ-013 SHALL have port tbl_sel, input, 1, selects the table: 0 = hi, 1 = lo.
REQ-014 SHALL have port tbl_addr, input, AW, table address; AW = EW+MHI+1, where EW = clog2(EMAX-EMIN).
REQ-015 SHALL have port tbl_wdata, input, 16, BF16 table entry.

Function
REQ-016 SHALL decode x as S = x[15], E = x[14:7], M = x[6:0]; Eadj = (E-(127+EMIN)) truncated to EW bits.
REQ-017 SHALL form the hi index as {Eadj, M[6:7-MHI], S}, AW bits.
REQ-018 SHALL form the lo index as {Eadj, M[6-MHI:0], S}, AW-MHI+(7-MHI) bits.
REQ-019 SHALL hold a hi table of 2^AW entries and a lo table of 2^(EW+8-MHI) entries, each 16 bits, as internal registers with synchronous read.
REQ-020 SHALL have a two-stage pipeline; the accept edge reads both tables into S1 and registers the class flags; the next advance edge registers the result into S2, which drives out_data and out_valid.
REQ-021 SHALL give a latency of exactly 2 edges, from accept to out_valid high, when there is no stall.
REQ-022 SHALL advance the whole pipeline when adv = !out_valid || out_ready; in_ready = adv; while stalled all stage registers hold, including table read data.
REQ-023 SHALL carry an S1 valid bit; bubbles propagate and out_valid = S2 valid.
REQ-024 SHALL sustain 1 result per cycle when in_valid and out_ready are held high.
REQ-025 SHALL classify x as NaN when E=255 and M!=0, giving 16'h7FC0.
REQ-026 SHALL classify x as big when not NaN and E >= 127+EMAX, giving {1'b0, {8{!S}}, 7'b0}.
REQ-027 SHALL classify x as small when E < 127+EMIN, giving 16'h3F80.
REQ-028 SHALL give bf16_mul(hi, lo) when x is in no class; priority is NaN > big > small > product.
REQ-029 SHALL make the product round-to-nearest-even, flush subnormal inputs and outputs to signed zero, and saturate overflow to +/-inf.
REQ-030 SHALL write tbl_wdata at tbl_addr on any edge with tbl_we high, independent of the handshake; the lo table uses only the low bits of tbl_addr.
REQ-031 SHALL return the pre-write value when a read and a write hit the same entry on the same edge.

Reset
REQ-032 SHALL, on rst, clear the S1 and S2 valid bits and force out_data to 16'h0000.
REQ-033 SHALL keep in_ready high on the first cycle after reset.
REQ-034 SHALL discard in-flight operands on reset mid-operation, with no output for them.
REQ-035 SHALL leave table contents unchanged by rst.

Structure
REQ-036 SHALL place in a shared package: the BF16 field constants, QNAN = 16'h7FC0, ONE = 16'h3F80, and the class enum {NORM, SMALL, BIG, NAN}.
REQ-037 SHALL instantiate exactly one sub-module, bf16_mul, which is combinational and 16x16 -> 16.

Verification
REQ-038 SHALL cover: load hi[0x0E0]=16'h402E and lo[0x70]=16'h3F80, then x=16'h3F80 -> out_data 16'h402E, 2 edges after accept.
REQ-039 SHALL cover: x=16'h4300 -> 16'h7F80; x=16'hC300 -> 16'h0000; x=16'h3B80 -> 16'h3F80; x=16'h7FC1 -> 16'h7FC0.
REQ-040 SHALL cover: a stream of 8 operands with out_ready low for 3 cycles mid-stream -> in_ready low during the stall, 8 results in order, none duplicated or lost.
REQ-041 SHALL cover: a tbl_we write to hi[0x0E0] on the same edge as x=16'h3F80 is accepted -> the old entry is used; the next x=16'h3F80 uses the new entry.
REQ-042 SHALL cover: rst asserted with 2 operands in flight -> out_valid low on the next cycle, no stale result, and table contents intact.
